// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - next-PC operation encodings shared by the control unit and the PC sequencer
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JR     = 3'd3,
        NPC_CALL   = 3'd4,
        NPC_RET    = 3'd5
    } npc_op_e;

    localparam int unsigned NPC_OP_W = 3;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full silently overwrites the oldest entry
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_ptr_inc;
    logic [PW-1:0]    w_ptr_dec;

    // DEPTH is a power of two, so pointer arithmetic wraps for free
    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= w_ptr_inc;
            if (r_count != FULL_CNT)
                r_count <= r_count + CW'(1);
        end else if (pop && r_count != '0) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            r_mem[w_ptr_inc] <= push_data;
    end

    assign top_data = r_mem[r_ptr];
    assign empty    = (r_count == '0);
    assign full     = (r_count == FULL_CNT);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC/EPC registers and next-PC selection with return-address stack and exception redirect
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h0000_4180,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [NPC_OP_W-1:0] npc_op,
    input  logic [25:0]         imm,
    input  logic [WIDTH-1:0]    pcjr,
    input  logic                exc,
    input  logic                eret,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    npc,
    output logic [WIDTH-1:0]    epc,
    output logic                misalign,
    output logic                ras_empty,
    output logic                ras_full
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_branch;
    logic [WIDTH-1:0] w_jump;
    logic [WIDTH-1:0] w_ret;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_redirect;
    logic             w_advance;
    logic             w_push;
    logic             w_pop;

    assign w_pc4    = r_pc + WIDTH'(4);
    assign w_branch = w_pc4 + {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
    assign w_jump   = {w_pc4[WIDTH-1:28], imm, 2'b00};
    assign w_ret    = ras_empty ? pcjr : w_ras_top;

    always_comb begin
        w_target = w_pc4;
        misalign = 1'b0;
        case (npc_op)
            NPC_BRANCH: w_target = w_branch;
            NPC_JUMP,
            NPC_CALL:   w_target = w_jump;
            NPC_JR: begin
                w_target = pcjr;
                misalign = (pcjr[1:0] != 2'b00);
            end
            NPC_RET: begin
                w_target = w_ret;
                misalign = (w_ret[1:0] != 2'b00);
            end
            default:    w_target = w_pc4;
        endcase
    end

    assign w_redirect = exc | misalign;

    always_comb begin
        npc = w_target;
        if (w_redirect)
            npc = EXC_VEC;
        else if (eret)
            npc = r_epc;
        else if (stall)
            npc = r_pc;
    end

    // Stack only moves when the call/return actually steers the PC
    assign w_advance = ~w_redirect & ~eret & ~stall;
    assign w_push    = w_advance & (npc_op == NPC_CALL);
    assign w_pop     = w_advance & (npc_op == NPC_RET);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_epc <= '0;
        end else begin
            r_pc <= npc;
            if (w_redirect)
                r_epc <= r_pc;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc4),
        .top_data  (w_ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc  = r_pc;
    assign epc = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  npc_op;
    logic [25:0] imm;
    logic [31:0] pcjr;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] epc;
    logic        misalign;
    logic        ras_empty;
    logic        ras_full;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .npc_op    (npc_op),
        .imm       (imm),
        .pcjr      (pcjr),
        .exc       (exc),
        .eret      (eret),
        .pc        (pc),
        .npc       (npc),
        .epc       (epc),
        .misalign  (misalign),
        .ras_empty (ras_empty),
        .ras_full  (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        npc_op = 3'd3;
        pcjr   = target;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; npc_op = 3'd0; imm = '0; pcjr = '0; exc = 1'b0; eret = 1'b0;
        step(); step();
        rst = 1'b0;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
        total++; if (ras_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    endtask

    task automatic test_plus4();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        npc_op = 3'd0;
        #1;
        total++; if (npc !== 32'h4) begin bad++; $display("FAIL plus4_npc got=%h exp=%h", npc, 32'h4); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL plus4_pc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
        end
    endtask

    task automatic test_branch();
        npc_op = 3'd1;
        imm    = 26'h000_FFFC;
        #1;
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL branch_npc got=%h exp=%h", npc, 32'h0); end
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h0); end
    endtask

    task automatic test_jump_stall();
        goto_pc(32'h1000_0010);
        npc_op = 3'd2;
        imm    = 26'h000_0040;
        step();
        total++; if (pc !== 32'h1000_0100) begin bad++; $display("FAIL jump_pc got=%h exp=%h", pc, 32'h1000_0100); end
        stall  = 1'b1;
        npc_op = 3'd4;
        #1;
        total++; if (npc !== 32'h1000_0100) begin bad++; $display("FAIL stall_npc got=%h exp=%h", npc, 32'h1000_0100); end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (pc !== 32'h1000_0100) begin bad++; $display("FAIL stall_pc%0d got=%h exp=%h", i, pc, 32'h1000_0100); end
            total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL stall_ras%0d got=%b exp=1", i, ras_empty); end
        end
        stall = 1'b0;
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [5];
        exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24; exp_ret[4] = 32'h600;
        for (int i = 1; i <= 5; i++) begin
            goto_pc(32'(i * 16));
            npc_op = 3'd4;
            imm    = 26'h000_0100;
            step();
            total++; if (pc !== 32'h400) begin bad++; $display("FAIL call%0d_pc got=%h exp=%h", i, pc, 32'h400); end
            if (i == 3) begin
                total++; if (ras_full !== 1'b0) begin bad++; $display("FAIL call3_full got=%b exp=0", ras_full); end
            end
            if (i == 4) begin
                total++; if (ras_full !== 1'b1) begin bad++; $display("FAIL call4_full got=%b exp=1", ras_full); end
            end
        end
        npc_op = 3'd5;
        pcjr   = 32'h600;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (npc !== exp_ret[i]) begin bad++; $display("FAIL ret%0d_npc got=%h exp=%h", i, npc, exp_ret[i]); end
            step();
            total++; if (pc !== exp_ret[i]) begin bad++; $display("FAIL ret%0d_pc got=%h exp=%h", i, pc, exp_ret[i]); end
            if (i == 2) begin
                total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL ret2_empty got=%b exp=0", ras_empty); end
            end
            if (i == 3) begin
                total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL ret3_empty got=%b exp=1", ras_empty); end
            end
        end
    endtask

    task automatic test_misalign_eret();
        goto_pc(32'h200);
        npc_op = 3'd3;
        pcjr   = 32'h0000_0102;
        #1;
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL misalign_flag got=%b exp=1", misalign); end
        total++; if (npc !== EXC_VEC) begin bad++; $display("FAIL misalign_npc got=%h exp=%h", npc, EXC_VEC); end
        step();
        total++; if (pc !== EXC_VEC) begin bad++; $display("FAIL misalign_pc got=%h exp=%h", pc, EXC_VEC); end
        total++; if (epc !== 32'h200) begin bad++; $display("FAIL misalign_epc got=%h exp=%h", epc, 32'h200); end
        npc_op = 3'd0;
        eret   = 1'b1;
        step();
        eret = 1'b0;
        total++; if (pc !== 32'h200) begin bad++; $display("FAIL eret_pc got=%h exp=%h", pc, 32'h200); end
    endtask

    task automatic test_exc_eret_stall();
        goto_pc(32'h2F0);
        npc_op = 3'd4;
        imm    = 26'h000_00C0;
        step();
        total++; if (pc !== 32'h300) begin bad++; $display("FAIL exc_setup_pc got=%h exp=%h", pc, 32'h300); end
        stall  = 1'b1;
        exc    = 1'b1;
        eret   = 1'b1;
        npc_op = 3'd5;
        pcjr   = 32'h0;
        #1;
        total++; if (npc !== EXC_VEC) begin bad++; $display("FAIL exc_npc got=%h exp=%h", npc, EXC_VEC); end
        step();
        stall = 1'b0; exc = 1'b0; eret = 1'b0;
        total++; if (pc !== EXC_VEC) begin bad++; $display("FAIL exc_pc got=%h exp=%h", pc, EXC_VEC); end
        total++; if (epc !== 32'h300) begin bad++; $display("FAIL exc_epc got=%h exp=%h", epc, 32'h300); end
        total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL exc_ras got=%b exp=0", ras_empty); end
        npc_op = 3'd5;
        pcjr   = 32'h800;
        #1;
        total++; if (npc !== 32'h2F4) begin bad++; $display("FAIL exc_ret_npc got=%h exp=%h", npc, 32'h2F4); end
        step();
    endtask

    task automatic test_reset_mid_call();
        for (int i = 0; i < 2; i++) begin
            npc_op = 3'd4;
            imm    = 26'h000_0100;
            step();
        end
        total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL mid_pre_empty got=%b exp=0", ras_empty); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_rst_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty got=%b exp=1", ras_empty); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL mid_rst_epc got=%h exp=%h", epc, 32'h0); end
        npc_op = 3'd5;
        pcjr   = 32'h700;
        #1;
        total++; if (npc !== 32'h700) begin bad++; $display("FAIL mid_ret_npc got=%h exp=%h", npc, 32'h700); end
        step();
        total++; if (pc !== 32'h700) begin bad++; $display("FAIL mid_ret_pc got=%h exp=%h", pc, 32'h700); end
    endtask

    initial begin
        test_reset();
        test_plus4();
        test_branch();
        test_jump_stall();
        test_ras_overflow();
        test_misalign_eret();
        test_exc_eret_stall();
        test_reset_mid_call();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined CPU: owns the PC register and computes the next PC. Supports the existing plus-4, branch, jump and register-jump modes, and adds a return-address stack for calls and returns, stall hold, an exception redirect with EPC capture, ERET, and trapping of misaligned register-jump targets. Sits between the control unit and instruction memory, replacing the separate PC register and next-PC logic.

## Interface
- WIDTH, 32: PC/address width; must be ≥ 29.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- EXC_VEC, 32'h0000_4180: exception handler address.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS.
- npc_op  in  3  0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 CALL, 5 RET; 6 and 7 behave as PLUS4.
- imm  in  26  instruction immediate or jump field.
- pcjr  in  WIDTH  register-jump target (rs value).
- exc  in  1  external exception request.
- eret  in  1  return from exception.
- pc  out  WIDTH  current PC (registered).
- npc  out  WIDTH  next PC (combinational).
- epc  out  WIDTH  saved exception PC (registered).
- misalign  out  1  this cycle's JR/RET target has non-zero bits [1:0] (combinational).
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.

## Operation
- Define pc4 = pc + 4, truncated modulo 2^WIDTH.
- Mode targets:
  - PLUS4: pc4.
  - BRANCH: pc4 + (sign-extended imm[15:0] << 2).
  - JUMP and CALL: {pc4[WIDTH-1:28], imm, 2'b00}.
  - JR: pcjr.
  - RET: RAS top if the stack is non-empty, otherwise pcjr.
- misalign is asserted only for JR and RET whose selected target has bits [1:0] ≠ 0.
- npc priority, highest first:
  1. exc or misalign: EXC_VEC.
  2. eret: epc.
  3. stall: pc.
  4. Otherwise the mode target.
- epc ← pc on any edge where exc or misalign is asserted (the faulting PC); unchanged otherwise.
- RAS is a circular buffer with a top pointer and a 0..RAS_DEPTH count. It changes only on a taken, unstalled, non-exception CALL or RET.
- CALL pushes pc4.
  - When full, the push overwrites the oldest entry and count stays at RAS_DEPTH; pointer wrap-around is silent.
- RET pops when count > 0.
  - When empty, falls back to pcjr; no pop, no underflow.
- eret and exc never alter the RAS.
- eret together with stall: eret wins. exc together with eret: exc wins, and epc is overwritten.

## Timing
- On reset: pc = RESET_PC, epc = 0, RAS count = 0, pointer = 0, ras_empty = 1, ras_full = 0. Stack contents need not be cleared.
- rst overrides every other input on the same edge.
- pc ← npc on every rising edge when not in reset; stall already folds in as npc = pc.
- Next-PC latency is zero cycles; it is a combinational function of pc, inputs and the registered RAS/epc.
- PC update latency is one cycle.
- RAS push/pop and count update on the same edge as the pc update. ras_empty and ras_full reflect the post-edge count.
- An exception mid-stall is taken immediately.
- Reset asserted mid-call discards all RAS state.

## Structure
- The NPC op encodings go in the shared control-encoding header alongside the existing NPC codes, with NPC_CALL = 4 and NPC_RET = 5 added.
- The header stays the single source of those encodings for the control unit and this block.
- One sub-module, pc_ras: a parametrised circular stack with push/pop/count/full/empty.
- The top level holds the PC and EPC registers plus the next-PC mux.

## Test plan
- Reset, then 3 PLUS4 cycles: pc = 0, 4, 8, 0xC. Branch at 0xC with imm = 16'hFFFC yields pc = 0x0.
- JUMP at 0x1000_0010 with imm = 26'h000_0040: pc = 0x1000_0100. stall high 2 cycles: pc held, RAS unchanged.
- RAS_DEPTH = 4: 5 CALLs from 0x10, 0x20, 0x30, 0x40, 0x50, then 5 RETs:
  - RETs go to 0x54, 0x44, 0x34, 0x24, then fall back to pcjr.
  - ras_full asserts after the 4th call; ras_empty asserts after the 4th RET.
- JR with pcjr = 0x0000_0102 at pc 0x200: misalign = 1, next pc = EXC_VEC, epc = 0x200. eret then returns pc to 0x200.
- exc and eret together while stall = 1 at pc 0x300: pc = EXC_VEC, epc = 0x300, RAS untouched.
- rst asserted mid-sequence with 2 RAS entries: pc = RESET_PC, ras_empty = 1. A following RET uses pcjr.
